// File: rtl/panel_pixel_loader.sv
// Byte-stream parser that turns {panel, addr_hi, addr_lo, R,G,B...} packets into LED panel write strobes.
// Optional statistics counters are built only when PIXEL_LOADER_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for byte0 (panel index)
// HDR_HI | waiting for address MSB
// HDR_LO | waiting for address LSB
// PIX_R  | waiting for red byte
// PIX_G  | waiting for green byte
// PIX_B  | waiting for blue byte; its acceptance issues the write
// DROP   | bad panel index, swallowing bytes until in_last
module panel_pixel_loader #(
    parameter int PANELS = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ctrl_en,
    output logic [PANELS-1:0] ctrl_wr,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [23:0]       ctrl_wdat,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        PIX_R  = 3'd3,
        PIX_G  = 3'd4,
        PIX_B  = 3'd5,
        DROP   = 3'd6
    } state_t;

    localparam logic [8:0] PANELS_LIM = 9'(PANELS);

    state_t            state_q, state_d;
    logic              ready_q;
    logic              accept;
    logic              bad_panel;
    logic [7:0]        panel_q;
    logic [7:0]        hi_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PANELS-1:0] wr_onehot;

    logic load_panel, load_hi, load_addr, load_r, load_g;
    logic do_write, do_done, do_err;

    assign in_ready  = ready_q;
    assign accept    = in_valid && ready_q;
    assign bad_panel = ({1'b0, in_data} >= PANELS_LIM);

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < PANELS; i++) begin
            wr_onehot[i] = (panel_q == 8'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_panel = 1'b0;
        load_hi    = 1'b0;
        load_addr  = 1'b0;
        load_r     = 1'b0;
        load_g     = 1'b0;
        do_write   = 1'b0;
        do_done    = 1'b0;
        do_err     = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_last) begin
                        do_err = 1'b1;
                    end else if (bad_panel) begin
                        state_d = DROP;
                    end else begin
                        load_panel = 1'b1;
                        state_d    = HDR_HI;
                    end
                end
                HDR_HI: begin
                    load_hi = 1'b1;
                    state_d = in_last ? IDLE : HDR_LO;
                    do_err  = in_last;
                end
                // A header that ends here carries no pixels, so it is malformed.
                HDR_LO: begin
                    load_addr = 1'b1;
                    state_d   = in_last ? IDLE : PIX_R;
                    do_err    = in_last;
                end
                PIX_R: begin
                    load_r  = 1'b1;
                    state_d = in_last ? IDLE : PIX_G;
                    do_err  = in_last;
                end
                PIX_G: begin
                    load_g  = 1'b1;
                    state_d = in_last ? IDLE : PIX_B;
                    do_err  = in_last;
                end
                PIX_B: begin
                    do_write = 1'b1;
                    do_done  = in_last;
                    state_d  = in_last ? IDLE : PIX_R;
                end
                DROP: begin
                    if (in_last) begin
                        do_err  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ready_q stays low for exactly the first cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q   <= 1'b0;
            panel_q   <= '0;
            hi_q      <= '0;
            r_q       <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            ctrl_en   <= 1'b0;
            ctrl_wr   <= '0;
            ctrl_addr <= '0;
            ctrl_wdat <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            ctrl_en  <= do_write;
            pkt_done <= do_done;
            pkt_err  <= do_err;
            if (load_panel) panel_q <= in_data;
            if (load_hi)    hi_q    <= in_data;
            if (load_r)     r_q     <= in_data;
            if (load_g)     g_q     <= in_data;
            if (load_addr)  addr_q  <= ADDR_W'({hi_q, in_data});
            if (do_write) begin
                ctrl_wr   <= wr_onehot;
                ctrl_addr <= addr_q;
                ctrl_wdat <= {r_q, g_q, in_data};
                addr_q    <= addr_q + ADDR_W'(1);
            end
        end
    end

`ifdef PIXEL_LOADER_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pkt_done && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (pkt_err && err_cnt_q != 16'hFFFF)  err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign pkt_count = 16'd0;
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_panel_pixel_loader.sv
// Self-checking bench for panel_pixel_loader: directed packets, a packet-level write model
// feeding a scoreboard queue, and a negedge monitor that pops and compares each write.
module tb_panel_pixel_loader;

    localparam int PANELS = 4;
    localparam int ADDR_W = 16;

    typedef struct {
        logic [PANELS-1:0] wr;
        logic [15:0]       addr;
        logic [23:0]       wdat;
        logic              done;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              ctrl_en;
    logic [PANELS-1:0] ctrl_wr;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [23:0]       ctrl_wdat;
    logic              pkt_done;
    logic              pkt_err;
    logic [15:0]       pkt_count;
    logic [15:0]       err_count;

    int tests = 0;
    int fails = 0;
    wr_t sb[$];
    logic [7:0] pkt[$];
    int exp_done = 0, exp_err = 0, done_seen = 0, err_seen = 0;
    int done_base = 0, err_base = 0;

    panel_pixel_loader #(.PANELS(PANELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (pkt_err) err_seen++;
            if (pkt_done) done_seen++;
            if (pkt_done && !ctrl_en) chk("done_without_write", 32'(ctrl_en), 32'd1);
            if (ctrl_en) begin
                chk("write_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("ctrl_wr", 32'(ctrl_wr), 32'(e.wr));
                    chk("ctrl_addr", 32'(ctrl_addr), 32'(e.addr));
                    chk("ctrl_wdat", 32'(ctrl_wdat), 32'(e.wdat));
                    chk("pkt_done_with_write", 32'(pkt_done), 32'(e.done));
                end
            end
        end
    end

    // Packet-level reference: complete triplets get written, anything malformed counts as an error.
    task automatic model_pkt();
        int n;
        int trip;
        bit err;
        logic [15:0] a;
        wr_t e;
        n = pkt.size();
        err = (n < 6) || (((n - 3) % 3) != 0) || (int'(pkt[0]) >= PANELS);
        if (int'(pkt[0]) < PANELS && n >= 3) begin
            a = {pkt[1], pkt[2]};
            trip = (n - 3) / 3;
            for (int t = 0; t < trip; t++) begin
                e.wr   = PANELS'(1) << pkt[0];
                e.addr = a + 16'(t);
                e.wdat = {pkt[3 + 3*t], pkt[4 + 3*t], pkt[5 + 3*t]};
                e.done = !err && (t == trip - 1);
                sb.push_back(e);
            end
        end
        if (err) exp_err++;
        else exp_done++;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int budget;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input int max_gap);
        model_pkt();
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i], (i == pkt.size() - 1), (i == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic settle_and_check(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_seen), 32'(exp_done));
        chk({tag, "_err_cnt"}, 32'(err_seen), 32'(exp_err));
`ifdef PIXEL_LOADER_STATS_EN
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_done - done_base));
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err - err_base));
`else
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_ctrl_en"}, 32'(ctrl_en), 32'd0);
        chk({tag, "_ctrl_wr"}, 32'(ctrl_wr), 32'd0);
        chk({tag, "_ctrl_addr"}, 32'(ctrl_addr), 32'd0);
        chk({tag, "_ctrl_wdat"}, 32'(ctrl_wdat), 32'd0);
        chk({tag, "_pulses"}, 32'({pkt_done, pkt_err}), 32'd0);
        chk({tag, "_stats"}, {pkt_count, err_count}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        #1;
        chk("ready_after_release", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_steady", 32'(in_ready), 32'd1);

        pkt = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
        send_pkt(0);
        settle_and_check("clean");
        chk("hold_en", 32'(ctrl_en), 32'd0);
        chk("hold_addr", 32'(ctrl_addr), 32'h0011);
        chk("hold_wdat", 32'(ctrl_wdat), 32'h112233);

        pkt = '{8'h00, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(0);
        settle_and_check("wrap");

        pkt = '{8'h07, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt(0);
        settle_and_check("bad_panel");

        pkt = '{8'h04, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_pkt(0);
        settle_and_check("panel_eq_lim");

        pkt = '{8'h03, 8'h12, 8'h34, 8'h0A, 8'h0B, 8'h0C};
        send_pkt(0);
        settle_and_check("panel_max");

        pkt = '{8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB};
        send_pkt(0);
        settle_and_check("truncated");

        pkt = '{8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h30};
        send_pkt(0);
        settle_and_check("after_trunc");

        pkt = '{8'h00, 8'h12, 8'h34};
        send_pkt(0);
        settle_and_check("hdr_lo_last");

        pkt = '{8'h01};
        send_pkt(0);
        settle_and_check("idle_last");

        pkt = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33};
        send_pkt(3);
        settle_and_check("stalled");

        // Partial packet up to the G byte, then reset: nothing may be emitted for it.
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 1);
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h01, 1'b0, 2);
        send_byte(8'h02, 1'b0, 0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        done_base = exp_done;
        err_base  = exp_err;
        reset = 1'b1;
        #1;
        chk("ready_after_rerelease", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        pkt = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(1);
        settle_and_check("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
